// File: rtl/lockable_register_bank.sv
// Bank of write-once configuration registers with per-register lock bits and a
// timed two-key unlock sequence that clears every lock without a reset.
module lockable_register_bank #(
    parameter int              DATA_W   = 16,
    parameter int              NUM_REGS = 4,
    parameter int              ADDR_W   = 2,
    parameter logic [DATA_W-1:0] KEY_A  = 16'hA5A5,
    parameter logic [DATA_W-1:0] KEY_B  = 16'h5A5A,
    parameter int              TIMEOUT  = 8
) (
    input  logic                Clk,
    input  logic                ip_resetn,
    input  logic                write,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   Data_in,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   Data_out,
    output logic [NUM_REGS-1:0] lock_status,
    output logic                wr_err,
    input  logic                key_write,
    input  logic [DATA_W-1:0]   key_data,
    output logic                key_err,
    output logic                unlock_pending
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GOT_A = 1'b1
    } state_t;

    logic [DATA_W-1:1]   r_data [NUM_REGS];
    logic [NUM_REGS-1:0] r_lock;
    logic [DATA_W-1:0]   r_dout;
    logic                r_wr_err;
    logic                r_key_err;
    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;

    logic [DATA_W-1:1]   w_data_ext [DEPTH];
    logic [DEPTH-1:0]    w_lock_ext;
    logic [DEPTH-1:0]    w_valid;
    logic                w_wr_ok;
    logic [NUM_REGS-1:0] w_lock_next;
    state_t              w_state_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_key_err_next;
    logic                w_unlock;

    // Full-address views: indices beyond NUM_REGS read as zero and are never valid.
    always_comb begin
        w_lock_ext = '0;
        w_valid    = '0;
        for (int i = 0; i < DEPTH; i++) w_data_ext[i] = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_lock_ext[i] = r_lock[i];
            w_valid[i]    = 1'b1;
            w_data_ext[i] = r_data[i];
        end
    end

    // NOTE: acceptance looks only at the lock flops, so an unlock landing in the
    // same cycle cannot let a write through to a register that was locked.
    assign w_wr_ok = write & w_valid[wr_addr] & ~w_lock_ext[wr_addr];

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_key_err_next = 1'b0;
        w_unlock       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (key_write) begin
                    if (key_data == KEY_A) begin
                        w_state_next = ST_GOT_A;
                        w_cnt_next   = '0;
                    end else begin
                        w_key_err_next = 1'b1;
                    end
                end
            end
            ST_GOT_A: begin
                if (key_write) begin
                    w_state_next = ST_IDLE;
                    if (key_data == KEY_B) w_unlock = 1'b1;
                    else                   w_key_err_next = 1'b1;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Unlock clears everything first; an accepted write then sets its own target.
    always_comb begin
        w_lock_next = w_unlock ? '0 : r_lock;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_ok && (wr_addr == ADDR_W'(i))) w_lock_next[i] = Data_in[0];
        end
    end

    // NOTE: the register array is reset too, because its contents are observable
    // through Data_out and must be deterministic after reset.
    always_ff @(posedge Clk or negedge ip_resetn) begin
        if (!ip_resetn) begin
            for (int i = 0; i < NUM_REGS; i++) r_data[i] <= '0;
            r_lock    <= '0;
            r_dout    <= '0;
            r_wr_err  <= 1'b0;
            r_key_err <= 1'b0;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_wr_ok && (wr_addr == ADDR_W'(i))) r_data[i] <= Data_in[DATA_W-1:1];
            end
            r_lock    <= w_lock_next;
            r_dout    <= {w_data_ext[rd_addr], w_lock_ext[rd_addr]};
            r_wr_err  <= write & ~w_wr_ok;
            r_key_err <= w_key_err_next;
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
        end
    end

    assign Data_out       = r_dout;
    assign lock_status    = r_lock;
    assign wr_err         = r_wr_err;
    assign key_err        = r_key_err;
    assign unlock_pending = (r_state == ST_GOT_A);

endmodule

// File: tb/tb_lockable_register_bank.sv
// Directed bench for lockable_register_bank (3 registers, TIMEOUT 8): vector table
// for the main flow plus hand sequences for timeout, same-cycle unlock and reset.
module tb_lockable_register_bank;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 3;
    localparam int ADDR_W   = 2;
    localparam int TIMEOUT  = 8;

    typedef struct {
        logic                w;
        logic [ADDR_W-1:0]   wa;
        logic [DATA_W-1:0]   din;
        logic [ADDR_W-1:0]   ra;
        logic                kw;
        logic [DATA_W-1:0]   kd;
        logic [DATA_W-1:0]   dout;
        logic [NUM_REGS-1:0] lock;
        logic                werr;
        logic                kerr;
        logic                pend;
    } vec_t;

    logic                Clk = 1'b0;
    logic                ip_resetn;
    logic                write;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   Data_in;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   Data_out;
    logic [NUM_REGS-1:0] lock_status;
    logic                wr_err;
    logic                key_write;
    logic [DATA_W-1:0]   key_data;
    logic                key_err;
    logic                unlock_pending;

    int n_checks   = 0;
    int n_failures = 0;

    lockable_register_bank #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
        .KEY_A(16'hA5A5), .KEY_B(16'h5A5A), .TIMEOUT(TIMEOUT)
    ) dut (
        .Clk(Clk), .ip_resetn(ip_resetn), .write(write), .wr_addr(wr_addr),
        .Data_in(Data_in), .rd_addr(rd_addr), .Data_out(Data_out),
        .lock_status(lock_status), .wr_err(wr_err), .key_write(key_write),
        .key_data(key_data), .key_err(key_err), .unlock_pending(unlock_pending)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [ADDR_W-1:0] wa,
                                input logic [DATA_W-1:0] din, input logic [ADDR_W-1:0] ra,
                                input logic kw, input logic [DATA_W-1:0] kd,
                                input logic [DATA_W-1:0] dout, input logic [NUM_REGS-1:0] lock,
                                input logic werr, input logic kerr, input logic pend);
        vec_t v;
        v.w = w; v.wa = wa; v.din = din; v.ra = ra; v.kw = kw; v.kd = kd;
        v.dout = dout; v.lock = lock; v.werr = werr; v.kerr = kerr; v.pend = pend;
        return v;
    endfunction

    // Drive at a falling edge, let one rising edge pass, compare at the next falling edge.
    task automatic step(input vec_t v, input string tag);
        write = v.w; wr_addr = v.wa; Data_in = v.din; rd_addr = v.ra;
        key_write = v.kw; key_data = v.kd;
        @(posedge Clk);
        @(negedge Clk);
        check({tag, "_dout"}, 32'(Data_out), 32'(v.dout));
        check({tag, "_lock"}, 32'(lock_status), 32'(v.lock));
        check({tag, "_wr_err"}, 32'(wr_err), 32'(v.werr));
        check({tag, "_key_err"}, 32'(key_err), 32'(v.kerr));
        check({tag, "_pending"}, 32'(unlock_pending), 32'(v.pend));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dout"}, 32'(Data_out), 32'h0);
        check({tag, "_lock"}, 32'(lock_status), 32'h0);
        check({tag, "_wr_err"}, 32'(wr_err), 32'h0);
        check({tag, "_key_err"}, 32'(key_err), 32'h0);
        check({tag, "_pending"}, 32'(unlock_pending), 32'h0);
    endtask

    vec_t tbl [18];

    initial begin
        //            w  wa  din       ra kw kd        dout      lock    we kе pd
        tbl[0]  = mk(1, 1, 16'h1235, 1, 0, 16'h0000, 16'h0000, 3'b010, 0, 0, 0);
        tbl[1]  = mk(1, 1, 16'hBEEF, 1, 0, 16'h0000, 16'h1235, 3'b010, 1, 0, 0);
        tbl[2]  = mk(1, 2, 16'h00F0, 1, 0, 16'h0000, 16'h1235, 3'b010, 0, 0, 0);
        tbl[3]  = mk(0, 0, 16'h0000, 2, 0, 16'h0000, 16'h00F0, 3'b010, 0, 0, 0);
        tbl[4]  = mk(1, 3, 16'hFFFF, 3, 0, 16'h0000, 16'h0000, 3'b010, 1, 0, 0);
        tbl[5]  = mk(1, 3, 16'h0001, 3, 0, 16'h0000, 16'h0000, 3'b010, 1, 0, 0);
        tbl[6]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3'b010, 0, 0, 0);
        tbl[7]  = mk(0, 0, 16'h0000, 1, 1, 16'hA5A5, 16'h1235, 3'b010, 0, 0, 1);
        tbl[8]  = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h1235, 3'b010, 0, 0, 1);
        tbl[9]  = mk(0, 0, 16'h0000, 1, 1, 16'h5A5A, 16'h1235, 3'b000, 0, 0, 0);
        tbl[10] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h1234, 3'b000, 0, 0, 0);
        tbl[11] = mk(1, 1, 16'h0001, 1, 0, 16'h0000, 16'h1234, 3'b010, 0, 0, 0);
        tbl[12] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0001, 3'b010, 0, 0, 0);
        tbl[13] = mk(0, 0, 16'h0000, 1, 1, 16'h1234, 16'h0001, 3'b010, 0, 1, 0);
        tbl[14] = mk(0, 0, 16'h0000, 1, 1, 16'hA5A5, 16'h0001, 3'b010, 0, 0, 1);
        tbl[15] = mk(0, 0, 16'h0000, 1, 1, 16'hA5A5, 16'h0001, 3'b010, 0, 1, 0);
        tbl[16] = mk(0, 0, 16'h0000, 1, 1, 16'h1234, 16'h0001, 3'b010, 0, 1, 0);
        tbl[17] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0001, 3'b010, 0, 0, 0);

        ip_resetn = 1'b0;
        write = 1'b0; wr_addr = '0; Data_in = '0; rd_addr = '0;
        key_write = 1'b0; key_data = '0;
        repeat (2) @(negedge Clk);
        check_all_zero("reset");
        ip_resetn = 1'b1;

        for (int i = 0; i < 18; i++) step(tbl[i], $sformatf("v%0d", i));

        // KEY_B arriving TIMEOUT cycles after KEY_A is too late.
        step(mk(0, 0, 16'h0, 1, 1, 16'hA5A5, 16'h0001, 3'b010, 0, 0, 1), "to_a");
        for (int i = 1; i < TIMEOUT; i++)
            step(mk(0, 0, 16'h0, 1, 0, 16'h0, 16'h0001, 3'b010, 0, 0, (i < TIMEOUT - 1)),
                 $sformatf("to_wait%0d", i));
        step(mk(0, 0, 16'h0, 1, 1, 16'h5A5A, 16'h0001, 3'b010, 0, 1, 0), "to_late_b");

        // KEY_B at TIMEOUT-1 cycles after KEY_A is the last accepted slot.
        step(mk(0, 0, 16'h0, 1, 1, 16'hA5A5, 16'h0001, 3'b010, 0, 0, 1), "bd_a");
        for (int i = 1; i < TIMEOUT - 1; i++)
            step(mk(0, 0, 16'h0, 1, 0, 16'h0, 16'h0001, 3'b010, 0, 0, 1),
                 $sformatf("bd_wait%0d", i));
        step(mk(0, 0, 16'h0, 1, 1, 16'h5A5A, 16'h0001, 3'b000, 0, 0, 0), "bd_b");
        step(mk(0, 0, 16'h0, 1, 0, 16'h0, 16'h0000, 3'b000, 0, 0, 0), "bd_read");

        // Unlock in the same cycle as a write to a register locked at cycle start.
        step(mk(1, 0, 16'h0003, 0, 0, 16'h0, 16'h0000, 3'b001, 0, 0, 0), "s1_lock0");
        step(mk(0, 0, 16'h0, 0, 1, 16'hA5A5, 16'h0003, 3'b001, 0, 0, 1), "s1_a");
        step(mk(1, 0, 16'h0003, 0, 1, 16'h5A5A, 16'h0003, 3'b000, 1, 0, 0), "s1_b_wr");
        step(mk(0, 0, 16'h0, 0, 0, 16'h0, 16'h0002, 3'b000, 0, 0, 0), "s1_read");

        // Unlock in the same cycle as a write to an unlocked register.
        step(mk(0, 0, 16'h0, 2, 1, 16'hA5A5, 16'h00F0, 3'b000, 0, 0, 1), "s2_a");
        step(mk(1, 2, 16'h0011, 2, 1, 16'h5A5A, 16'h00F0, 3'b100, 0, 0, 0), "s2_b_wr");
        step(mk(0, 0, 16'h0, 2, 0, 16'h0, 16'h0011, 3'b100, 0, 0, 0), "s2_read");

        // Reset while unlock is pending and a wr_err pulse is live.
        step(mk(1, 3, 16'h0, 2, 1, 16'hA5A5, 16'h0011, 3'b100, 1, 0, 1), "r_a");
        write = 1'b0; key_write = 1'b0;
        ip_resetn = 1'b0;
        #1;
        check_all_zero("r_async");
        @(negedge Clk);
        ip_resetn = 1'b1;
        step(mk(0, 0, 16'h0, 2, 0, 16'h0, 16'h0000, 3'b000, 0, 0, 0), "r_read2");
        step(mk(0, 0, 16'h0, 1, 1, 16'h5A5A, 16'h0000, 3'b000, 0, 1, 0), "r_b_idle");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule
